dmi_req_sched: RTL

- DM-side scheduler for DMI traffic crossing the async FIFO pair between the DTM (tck domain) and the DM (dm_clk domain).
- Pops one DMI request at a time from the dtm2dm FIFO and issues it to the DM register file over a valid/ready request port.
- Waits for the register response, or a timeout, then pushes exactly one DMI response into the dm2dtm FIFO.
- Holds strictly one outstanding transaction, so request ordering is preserved end-to-end.

---
 rtl/dmi_req_sched_pkg.sv | 25 ++
 rtl/dmi_req_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dmi_req_sched_pkg.sv
// Shared DMI definitions: op/response encodings, {addr,data,op} field offsets
// and the request scheduler state enum.
package dmi_req_sched_pkg;

  localparam logic [1:0] DMI_OP_NOP    = 2'd0;
  localparam logic [1:0] DMI_OP_READ   = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE  = 2'd2;
  localparam logic [1:0] DMI_OP_RSVD   = 2'd3;

  localparam logic [1:0] DMI_RSP_OK     = 2'd0;
  localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
  localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

  localparam int DMI_OP_LSB   = 0;
  localparam int DMI_DATA_LSB = 2;
  localparam int DMI_ADDR_LSB = 34;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_PUSH
  } state_e;

endpackage

// File: rtl/dmi_req_sched.sv
// DM-side DMI scheduler: pops one request from the dtm2dm FIFO, runs it against
// the register file with a timeout, and pushes exactly one response to dm2dtm.
module dmi_req_sched
  import dmi_req_sched_pkg::*;
#(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             dm_clk,
  input  logic             dm_rst,
  input  logic             dtm2dm_empty,
  output logic             dtm2dm_ren,
  input  logic [ABITS+33:0] dtm2dm_data_out,
  input  logic             dm2dtm_full,
  output logic             dm2dtm_wen,
  output logic [ABITS+33:0] dm2dtm_data_in,
  output logic             reg_req_valid,
  input  logic             reg_req_ready,
  output logic             reg_req_wr,
  output logic [ABITS-1:0] reg_req_addr,
  output logic [31:0]      reg_req_wdata,
  input  logic             reg_rsp_valid,
  input  logic [31:0]      reg_rsp_rdata,
  input  logic             reg_rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ABITS-1:0]  addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [ABITS+33:0] rsp_q, rsp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [ABITS-1:0]  reqAddr;
  logic [31:0]       reqData;
  logic [1:0]        reqOp;

  assign reqAddr = dtm2dm_data_out[DMI_ADDR_LSB +: ABITS];
  assign reqData = dtm2dm_data_out[DMI_DATA_LSB +: 32];
  assign reqOp   = dtm2dm_data_out[DMI_OP_LSB +: 2];

  always_ff @(posedge dm_clk or posedge dm_rst) begin
    if (dm_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  // The pop is gated by reset so a request is never drained while it cannot be latched.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wr_d          = wr_q;
    rsp_d         = rsp_q;
    cnt_d         = cnt_q;
    dtm2dm_ren    = 1'b0;
    dm2dtm_wen    = 1'b0;
    reg_req_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dtm2dm_ren = !dtm2dm_empty && !dm_rst;
        if (!dtm2dm_empty) begin
          addr_d  = reqAddr;
          wdata_d = reqData;
          wr_d    = (reqOp == DMI_OP_WRITE);
          case (reqOp)
            DMI_OP_READ, DMI_OP_WRITE: state_d = ST_ISSUE;
            DMI_OP_NOP: begin
              rsp_d   = {reqAddr, 32'h0, DMI_RSP_OK};
              state_d = ST_PUSH;
            end
            default: begin
              rsp_d   = {reqAddr, 32'h0, DMI_RSP_FAILED};
              state_d = ST_PUSH;
            end
          endcase
        end
      end

      ST_ISSUE: begin
        reg_req_valid = 1'b1;
        if (reg_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RSP;
        end
      end

      // A response arriving on the timeout cycle still takes priority.
      ST_WAIT_RSP: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (reg_rsp_valid) begin
          rsp_d   = {addr_q,
                     (!wr_q && !reg_rsp_err) ? reg_rsp_rdata : 32'h0,
                     reg_rsp_err ? DMI_RSP_FAILED : DMI_RSP_OK};
          state_d = ST_PUSH;
        end else if (cnt_q == CNT_LAST) begin
          rsp_d   = {addr_q, 32'h0, DMI_RSP_FAILED};
          state_d = ST_PUSH;
        end
      end

      ST_PUSH: begin
        dm2dtm_wen = !dm2dtm_full;
        if (!dm2dtm_full) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign reg_req_wr     = wr_q;
  assign reg_req_addr   = addr_q;
  assign reg_req_wdata  = wdata_q;
  assign dm2dtm_data_in = rsp_q;

endmodule
